// File: rtl/spi_slave_miso_tx_if.sv
// Core-side transmit handshake for the SPI slave MISO path.
interface spi_slave_miso_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    // Core drives words in; the transmitter reports buffer space.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/spi_slave_miso_tx.sv
// SPI slave transmit path: one-word holding buffer feeding an MSB-first
// shift register that advances on shift_en while cs_n is low.
module spi_slave_miso_tx #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          CNT_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] FILL      = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_n_i,
    input  logic                 shift_en_i,
    spi_slave_miso_tx_if.slave   tx_if,
    output logic                 miso_o,
    output logic                 miso_oe_o,
    output logic                 tx_done_o,
    output logic                 tx_underrun_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    localparam logic [CNT_WIDTH-1:0] LastBit = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic                  load;
    logic                  accept;

    assign tx_if.tx_ready = ~hold_full_q;
    assign accept         = tx_if.tx_valid & ~hold_full_q;

    // Next-state: sequencing, load-source priority and holding-buffer fill.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (!cs_n_i) begin
                    load    = 1'b1;
                    state_d = StActive;
                end
            end
            StActive: begin
                // Abort wins over a coincident shift strobe.
                if (cs_n_i) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                end else if (shift_en_i) begin
                    if (bit_cnt_q == LastBit) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        load      = 1'b1;
                    end else begin
                        shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            if (hold_full_q) begin
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_if.tx_valid) begin
                // Bypass: the handshake completes straight into the shifter.
                shreg_d = tx_if.tx_data;
            end else begin
                shreg_d    = FILL;
                underrun_d = 1'b1;
            end
        end

        if (accept && !load) begin
            hold_d      = tx_if.tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    // Pad drive only while a transfer is active.
    always_comb begin
        miso_oe_o     = (state_q == StActive);
        miso_o        = (state_q == StActive) ? shreg_q[DATA_WIDTH-1] : 1'b0;
        tx_done_o     = done_q;
        tx_underrun_o = underrun_q;
    end

endmodule

// File: tb/tb_spi_slave_miso_tx.sv
// Self-checking bench for spi_slave_miso_tx: table of single-word transfers
// plus hand-written multi-word, bypass, abort and reset sequences.
module tb_spi_slave_miso_tx;

    logic clk;
    logic rst_n;
    logic cs_n;
    logic shift_en;
    logic miso;
    logic miso_oe;
    logic tx_done;
    logic tx_underrun;

    int errors;
    int checks;
    int done_cnt;
    int und_cnt;
    logic exp_q[$];

    spi_slave_miso_tx_if #(.DATA_WIDTH(8)) u_if ();

    spi_slave_miso_tx #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (3),
        .FILL      (8'h00)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_n_i       (cs_n),
        .shift_en_i   (shift_en),
        .tx_if        (u_if.slave),
        .miso_o       (miso),
        .miso_oe_o    (miso_oe),
        .tx_done_o    (tx_done),
        .tx_underrun_o(tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       strobe_at_cs;
        logic [7:0] exp_word;
        int         exp_underrun;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_done) done_cnt++;
        if (tx_underrun) und_cnt++;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
    endtask

    task automatic check_bit(input string name);
        logic e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected queued bit", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {31'd0, miso}, {31'd0, e});
        end
    endtask

    task automatic strobe(input string name);
        check_bit(name);
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = w;
        tick();
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
    endtask

    initial begin
        int d0;
        int u0;
        errors        = 0;
        checks        = 0;
        done_cnt      = 0;
        und_cnt       = 0;
        rst_n         = 1'b0;
        cs_n          = 1'b1;
        shift_en      = 1'b0;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;

        vecs[0] = '{data: 8'hA5, valid: 1'b1, strobe_at_cs: 1'b1, exp_word: 8'hA5, exp_underrun: 0};
        vecs[1] = '{data: 8'h00, valid: 1'b0, strobe_at_cs: 1'b0, exp_word: 8'h00, exp_underrun: 1};
        vecs[2] = '{data: 8'h96, valid: 1'b1, strobe_at_cs: 1'b0, exp_word: 8'h96, exp_underrun: 0};
        vecs[3] = '{data: 8'h7E, valid: 1'b1, strobe_at_cs: 1'b1, exp_word: 8'h7E, exp_underrun: 0};

        // Reset state.
        #1;
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_oe", {31'd0, miso_oe}, 0);
        check("rst_done", {31'd0, tx_done}, 0);
        check("rst_underrun", {31'd0, tx_underrun}, 0);
        check("rst_ready", {31'd0, u_if.tx_ready}, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Table of single-word transfers.
        foreach (vecs[i]) begin
            d0 = done_cnt;
            u0 = und_cnt;
            if (vecs[i].valid) begin
                check("ready_before", {31'd0, u_if.tx_ready}, 1);
                send_word(vecs[i].data);
                check("ready_after_accept", {31'd0, u_if.tx_ready}, 0);
            end
            cs_n     = 1'b0;
            shift_en = vecs[i].strobe_at_cs;
            tick();
            shift_en = 1'b0;
            push_word(vecs[i].exp_word);
            check("oe_on", {31'd0, miso_oe}, 1);
            check("start_underrun", und_cnt - u0, vecs[i].exp_underrun);
            check("ready_after_load", {31'd0, u_if.tx_ready}, 1);
            for (int b = 0; b < 7; b++) strobe("vec_bit");
            check("mid_done", done_cnt - d0, 0);
            check("mid_underrun", und_cnt - u0, vecs[i].exp_underrun);
            strobe("vec_last_bit");
            check("done_once", done_cnt - d0, 1);
            // Empty buffer at word end reloads FILL.
            check("tail_underrun", und_cnt - u0, vecs[i].exp_underrun + 1);
            cs_n = 1'b1;
            tick();
            check("oe_off", {31'd0, miso_oe}, 0);
            check("miso_off", {31'd0, miso}, 0);
            check("queue_drained", exp_q.size(), 0);
            tick();
        end

        // Back-to-back: 0x3C then 0xC3 buffered during the first word.
        d0 = done_cnt;
        u0 = und_cnt;
        send_word(8'h3C);
        cs_n = 1'b0;
        tick();
        push_word(8'h3C);
        for (int b = 0; b < 16; b++) begin
            strobe("b2b_bit");
            if (b == 0) begin
                send_word(8'hC3);
                push_word(8'hC3);
                check("b2b_buffered", {31'd0, u_if.tx_ready}, 0);
            end
            if (b == 7) check("b2b_no_gap_underrun", und_cnt - u0, 0);
        end
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_ready", {31'd0, u_if.tx_ready}, 1);
        cs_n = 1'b1;
        tick();
        tick();

        // Bypass: 0x81 offered on the last strobe with an empty buffer.
        d0 = done_cnt;
        send_word(8'h42);
        cs_n = 1'b0;
        tick();
        push_word(8'h42);
        u0 = und_cnt;
        for (int b = 0; b < 7; b++) strobe("byp_first_bit");
        check_bit("byp_last_bit");
        shift_en      = 1'b1;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'h81;
        tick();
        shift_en      = 1'b0;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        push_word(8'h81);
        check("byp_no_underrun", und_cnt - u0, 0);
        check("byp_not_buffered", {31'd0, u_if.tx_ready}, 1);
        tick();
        for (int b = 0; b < 8; b++) strobe("byp_bit");
        check("byp_done", done_cnt - d0, 2);
        cs_n = 1'b1;
        tick();
        tick();

        // Abort after 3 strobes; buffered 0x0F goes out next transaction.
        d0 = done_cnt;
        send_word(8'hF0);
        cs_n = 1'b0;
        tick();
        push_word(8'hF0);
        send_word(8'h0F);
        for (int b = 0; b < 3; b++) strobe("abort_bit");
        cs_n     = 1'b1;
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        check("abort_oe", {31'd0, miso_oe}, 0);
        check("abort_miso", {31'd0, miso}, 0);
        check("abort_ready", {31'd0, u_if.tx_ready}, 0);
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        exp_q.delete();
        u0   = und_cnt;
        cs_n = 1'b0;
        tick();
        push_word(8'h0F);
        check("resume_no_underrun", und_cnt - u0, 0);
        for (int b = 0; b < 8; b++) strobe("resume_bit");
        check("resume_done", done_cnt - d0, 1);
        cs_n = 1'b1;
        tick();
        tick();

        // Reset mid-word with a word waiting in the buffer.
        send_word(8'hFF);
        cs_n = 1'b0;
        tick();
        push_word(8'hFF);
        send_word(8'hAA);
        for (int b = 0; b < 4; b++) strobe("rst_mid_bit");
        check("pre_rst_oe", {31'd0, miso_oe}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", {31'd0, miso_oe}, 0);
        check("mid_rst_miso", {31'd0, miso}, 0);
        check("mid_rst_ready", {31'd0, u_if.tx_ready}, 1);
        check("mid_rst_done", {31'd0, tx_done}, 0);
        check("mid_rst_underrun", {31'd0, tx_underrun}, 0);
        exp_q.delete();
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
